// File: rtl/rd_fram_pkg.sv
// Shared types, default widths and helpers for the frame-buffer read path.
package rd_fram_pkg;

  localparam int unsigned DDR_DQ_WORD_W = 256;
  localparam int unsigned PIX_WORD_W    = 32;

  typedef enum logic {
    SLICE_LSB_FIRST = 1'b0,
    SLICE_MSB_FIRST = 1'b1
  } slice_order_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rd_fram_sdp_mem.sv
// Inferred simple-dual-port RAM: one write port, one synchronous read port, no output register.
module rd_fram_sdp_mem
  import rd_fram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DDR_DQ_WORD_W,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

  // rd_data holds its value while rd_en is low; the top relies on this as the stage register.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/rd_fram_gearbox_fifo.sv
// Wide-to-narrow read FIFO: circular storage, stage register and slicing hold register.
// Optional rd_level output enabled by defining RD_FRAM_GEARBOX_LEVEL_EN.
module rd_fram_gearbox_fifo
  import rd_fram_pkg::*;
#(
  parameter int unsigned WR_DATA_WIDTH = DDR_DQ_WORD_W,
  parameter int unsigned RD_DATA_WIDTH = PIX_WORD_W,
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned AF_MARGIN     = 4,
  parameter bit          MSB_FIRST     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  output logic                     full,
  output logic                     almost_full,
  output logic [ADDR_WIDTH:0]      wr_count,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [RD_DATA_WIDTH-1:0] m_data,
`ifdef RD_FRAM_GEARBOX_LEVEL_EN
  output logic [ADDR_WIDTH+clog2(WR_DATA_WIDTH/RD_DATA_WIDTH):0] rd_level,
`endif
  output logic                     overflow
);

  localparam int unsigned RATIO = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int unsigned SEL_W = clog2(RATIO);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam slice_order_e ORDER = MSB_FIRST ? SLICE_MSB_FIRST : SLICE_LSB_FIRST;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RATIO - 1);
  localparam logic [PW-1:0]    AF_LEVEL = PW'(DEPTH - AF_MARGIN);

  if (RATIO < 2 || (1 << SEL_W) != RATIO || RATIO * RD_DATA_WIDTH != WR_DATA_WIDTH) begin : g_bad_ratio
    $error("WR_DATA_WIDTH/RD_DATA_WIDTH must be a power of 2, at least 2");
  end
  if (AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_margin
    $error("AF_MARGIN out of range");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
  logic          full_q, full_d, af_q, af_d, overflow_q, overflow_d;
  logic [PW-1:0] wr_count_q;
  logic          stg_vld_q, stg_vld_d, hold_vld_q, hold_vld_d;
  logic [SEL_W-1:0] sel_q, sel_d, slice_idx;
  logic [RATIO-1:0][RD_DATA_WIDTH-1:0] hold_q, hold_d;
  logic [WR_DATA_WIDTH-1:0] mem_rdata;
  logic wr_acc, empty, accept, last_acc, hold_load, rd_issue;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    wr_acc    = wr_en && !full_q && !flush;
    accept    = hold_vld_q && m_ready;
    last_acc  = accept && (sel_q == SEL_LAST);
    hold_load = stg_vld_q && (!hold_vld_q || last_acc);
    // The stage is free next cycle if it is empty now or hands its word to hold this cycle.
    rd_issue  = !empty && (!stg_vld_q || hold_load) && !flush;

    wr_ptr_d   = flush ? '0 : wr_ptr_q + PW'(wr_acc);
    rd_ptr_d   = flush ? '0 : rd_ptr_q + PW'(rd_issue);
    count_d    = wr_ptr_d - rd_ptr_d;
    full_d     = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                 (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
    af_d       = (count_d >= AF_LEVEL);
    overflow_d = flush ? 1'b0 : (overflow_q || (wr_en && full_q));

    stg_vld_d  = flush ? 1'b0 : (rd_issue ? 1'b1 : (hold_load ? 1'b0 : stg_vld_q));
    hold_vld_d = flush ? 1'b0 : (hold_load ? 1'b1 : (last_acc ? 1'b0 : hold_vld_q));
    hold_d     = hold_load ? mem_rdata : hold_q;
    if (flush || hold_load) sel_d = '0;
    else if (accept)        sel_d = sel_q + 1'b1;
    else                    sel_d = sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_count_q <= '0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      overflow_q <= 1'b0;
      stg_vld_q  <= 1'b0;
      hold_vld_q <= 1'b0;
      sel_q      <= '0;
      hold_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_count_q <= count_d;
      full_q     <= full_d;
      af_q       <= af_d;
      overflow_q <= overflow_d;
      stg_vld_q  <= stg_vld_d;
      hold_vld_q <= hold_vld_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
    end
  end

  rd_fram_sdp_mem #(
    .DATA_WIDTH(WR_DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data(wr_data),
    .rd_en  (rd_issue),
    .rd_addr(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data(mem_rdata)
  );

  always_comb begin
    slice_idx = (ORDER == SLICE_MSB_FIRST) ? (SEL_LAST - sel_q) : sel_q;
    m_data    = hold_q[slice_idx];
  end

  assign m_valid     = hold_vld_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wr_count    = wr_count_q;
  assign overflow    = overflow_q;

`ifdef RD_FRAM_GEARBOX_LEVEL_EN
  localparam int unsigned LW = ADDR_WIDTH + SEL_W + 1;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    level_d = LW'(wr_count_q) << SEL_W;
    if (stg_vld_q)  level_d = level_d + LW'(RATIO);
    if (hold_vld_q) level_d = level_d + LW'(RATIO) - LW'(sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign rd_level = level_q;
`endif

endmodule

// File: tb/tb_rd_fram_gearbox_fifo.sv
// Bench for rd_fram_gearbox_fifo: default instance (a) and a 16-deep MSB-first instance (b).
module tb_rd_fram_gearbox_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_flush, a_wr_en, a_m_ready, b_flush, b_wr_en, b_m_ready;
  logic [255:0] a_wr_data, b_wr_data;
  logic a_full, a_af, a_mv, a_ov, b_full, b_af, b_mv, b_ov;
  logic [9:0] a_wc;
  logic [4:0] b_wc;
  logic [31:0] a_md, b_md;
`ifdef RD_FRAM_GEARBOX_LEVEL_EN
  logic [12:0] a_lvl;
  logic [7:0]  b_lvl;
`endif

  rd_fram_gearbox_fifo u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .full(a_full), .almost_full(a_af), .wr_count(a_wc), .m_valid(a_mv), .m_ready(a_m_ready),
`ifdef RD_FRAM_GEARBOX_LEVEL_EN
    .rd_level(a_lvl),
`endif
    .m_data(a_md), .overflow(a_ov)
  );

  rd_fram_gearbox_fifo #(.ADDR_WIDTH(4), .MSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .full(b_full), .almost_full(b_af), .wr_count(b_wc), .m_valid(b_mv), .m_ready(b_m_ready),
`ifdef RD_FRAM_GEARBOX_LEVEL_EN
    .rd_level(b_lvl),
`endif
    .m_data(b_md), .overflow(b_ov)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endfunction

  // Expected narrow stream: slices of each accepted wide word, in the instance's slice order.
  function automatic void push_word(int k, logic [255:0] w);
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = (k == 1) ? 7 - i : i;
      if (k == 0) exp_a.push_back(w[idx*32 +: 32]);
      else        exp_b.push_back(w[idx*32 +: 32]);
    end
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(int k, logic en, logic [255:0] d);
    if (k == 0) begin a_wr_en = en; a_wr_data = d; end
    else        begin b_wr_en = en; b_wr_data = d; end
  endtask

  task automatic set_ready(int k, logic r);
    if (k == 0) a_m_ready = r;
    else        b_m_ready = r;
  endtask

  function automatic logic mv_of(int k);
    return (k == 0) ? a_mv : b_mv;
  endfunction

  function automatic logic [31:0] md_of(int k);
    return (k == 0) ? a_md : b_md;
  endfunction

  // Per-cycle compare: stream order, stall stability and flag consistency.
  logic [31:0] prev_md [2];
  bit          prev_stall [2];
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        logic mv_s, mr_s, fl_s, af_s;
        logic [31:0] md_s;
        int wcv, dep, qn;
        mv_s = (k == 0) ? a_mv : b_mv;
        mr_s = (k == 0) ? a_m_ready : b_m_ready;
        fl_s = (k == 0) ? a_full : b_full;
        af_s = (k == 0) ? a_af : b_af;
        md_s = (k == 0) ? a_md : b_md;
        wcv  = (k == 0) ? int'(a_wc) : int'(b_wc);
        dep  = (k == 0) ? 512 : 16;
        qn   = (k == 0) ? exp_a.size() : exp_b.size();
        if (prev_stall[k] && mv_s) check("hold_stable", md_s, prev_md[k]);
        if (mv_s && mr_s) begin
          check("stream_avail", 32'(qn > 0), 32'd1);
          if (qn > 0) check("stream_data", md_s, (k == 0) ? exp_a.pop_front() : exp_b.pop_front());
        end
        check("full_flag", 32'(fl_s), 32'(wcv == dep));
        check("af_flag", 32'(af_s), 32'(wcv >= dep - 4));
        prev_stall[k] = mv_s && !mr_s;
        prev_md[k]    = md_s;
      end
    end
  end

  // One wide word in, then 8 narrow words on consecutive cycles starting two edges later.
  task automatic single_word_test(int k, logic [255:0] w, string tag);
    set_ready(k, 1'b1);
    for (int c = 0; c < 11; c++) begin
      bit ev;
      int idx;
      if (c == 0) begin set_wr(k, 1'b1, w); push_word(k, w); end
      tick();
      set_wr(k, 1'b0, '0);
      ev = (c >= 2) && (c <= 9);
      check({tag, "_valid"}, 32'(mv_of(k)), 32'(ev));
      if (ev) begin
        idx = (k == 1) ? 7 - (c - 2) : c - 2;
        check({tag, "_data"}, md_of(k), w[idx*32 +: 32]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] w;
    rst_n = 1'b0;
    a_flush = 0; a_wr_en = 0; a_m_ready = 0; a_wr_data = '0;
    b_flush = 0; b_wr_en = 0; b_m_ready = 0; b_wr_data = '0;

    // Reset values
    #12;
    check("rst_full_a", 32'(a_full), 0);    check("rst_full_b", 32'(b_full), 0);
    check("rst_af_a", 32'(a_af), 0);        check("rst_af_b", 32'(b_af), 0);
    check("rst_wc_a", 32'(a_wc), 0);        check("rst_wc_b", 32'(b_wc), 0);
    check("rst_valid_a", 32'(a_mv), 0);     check("rst_valid_b", 32'(b_mv), 0);
    check("rst_data_a", a_md, 0);           check("rst_data_b", b_md, 0);
    check("rst_ovf_a", 32'(a_ov), 0);       check("rst_ovf_b", 32'(b_ov), 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_valid_a", 32'(a_mv), 0);
      check("idle_valid_b", 32'(b_mv), 0);
    end

    // Slice order: slice i holds value i
    w = '0;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'(i);
    single_word_test(0, w, "order_lsb");
    single_word_test(1, w, "order_msb");

    // Throughput: four back-to-back words, 32 consecutive valid cycles
    a_m_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if (c < 4) begin w = rand_word(); set_wr(0, 1'b1, w); push_word(0, w); end
      tick();
      set_wr(0, 1'b0, '0);
      check("thru_valid", 32'(a_mv), 32'((c >= 2) && (c < 34)));
    end

    // Random backpressure over 100 words
    for (int c = 0; c < 100; c++) begin
      w = rand_word();
      set_wr(0, 1'b1, w);
      push_word(0, w);
      a_m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    set_wr(0, 1'b0, '0);
    for (int c = 0; c < 4000 && exp_a.size() > 0; c++) begin
      a_m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    a_m_ready = 1'b1;
    repeat (4) tick();
    check("bp_drained", 32'(exp_a.size()), 0);
    check("bp_idle_valid", 32'(a_mv), 0);

    // Reset asserted mid-stream
    a_m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      w = rand_word(); set_wr(0, 1'b1, w); push_word(0, w); tick();
    end
    set_wr(0, 1'b0, '0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(a_mv), 0);
    check("mid_rst_wc", 32'(a_wc), 0);
    exp_a.delete();
    exp_b.delete();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post_rst_valid", 32'(a_mv), 0);
    end

    // Full / overflow on the 16-deep instance with the consumer stalled
    b_m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      w = rand_word();
      set_wr(1, 1'b1, w);
      if (c < 18) push_word(1, w);  // 16 in storage plus stage and hold
      tick();
      if (c == 12) begin check("af_wc11", 32'(b_wc), 11); check("af_low", 32'(b_af), 0); end
      if (c == 13) begin check("af_wc12", 32'(b_wc), 12); check("af_high", 32'(b_af), 1); end
      if (c == 16) check("full_low", 32'(b_full), 0);
      if (c == 17) begin check("full_wc16", 32'(b_wc), 16); check("full_high", 32'(b_full), 1); end
    end
    set_wr(1, 1'b0, '0);
    tick();
    check("ovf_set", 32'(b_ov), 1);
    check("ovf_wc", 32'(b_wc), 16);
    b_m_ready = 1'b1;
    for (int c = 0; c < 400 && exp_b.size() > 0; c++) tick();
    repeat (10) tick();
    check("full_drained", 32'(exp_b.size()), 0);
    check("full_idle_valid", 32'(b_mv), 0);
    check("ovf_sticky", 32'(b_ov), 1);

    // Flush with five words queued
    b_m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      w = rand_word(); set_wr(1, 1'b1, w); push_word(1, w); tick();
    end
    set_wr(1, 1'b0, '0);
    repeat (2) tick();
    check("pre_flush_valid", 32'(b_mv), 1);
    b_flush = 1'b1;
    set_wr(1, 1'b1, rand_word());  // discarded by the flush
    tick();
    b_flush = 1'b0;
    set_wr(1, 1'b0, '0);
    exp_b.delete();
    check("flush_valid", 32'(b_mv), 0);
    check("flush_wc", 32'(b_wc), 0);
    check("flush_ovf", 32'(b_ov), 0);
    check("flush_full", 32'(b_full), 0);
    single_word_test(1, rand_word(), "post_flush");

    repeat (4) tick();
    check("end_queue_a", 32'(exp_a.size()), 0);
    check("end_queue_b", 32'(exp_b.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
